// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response and decode-side head signals of the fetch front end
interface fetch_queue_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_valid;
    logic [INS_W-1:0] imem_rdata;
    logic             id_ready;
    logic             id_valid;
    logic [PC_W-1:0]  id_pc;
    logic [INS_W-1:0] id_instr;
    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_instr,
        input  imem_valid, imem_rdata, id_ready
    );
    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_instr,
        output imem_valid, imem_rdata, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues one outstanding imem request at a time and buffers {pc, instr} for decode
module fetch_queue #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    input  logic                       halt,
    fetch_queue_if.master              bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
    state_t state, state_n;
    logic [PC_W-1:0] fpc, addr_q;
    logic req_q, issue, push, pop, empty;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [PC_W-1:0] pc_mem [DEPTH];
    logic [INS_W-1:0] ins_mem [DEPTH];
    assign empty = occupancy == '0;
    // Only issue with a free slot, so the single response in flight always fits.
    assign issue = state == IDLE && !halt && !redirect && occupancy < OW'(DEPTH);
    assign push = state == WAIT && bus.imem_valid && !redirect;
    assign pop = !empty && bus.id_ready;
    assign bus.imem_req = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.id_valid = !empty;
    assign bus.id_pc = empty ? '0 : pc_mem[rd_ptr];
    assign bus.id_instr = empty ? '0 : ins_mem[rd_ptr];
    always_comb begin
        state_n = state;
        if (redirect)
            state_n = (state != IDLE && !bus.imem_valid) ? DROP : IDLE;
        else if (issue)
            state_n = WAIT;
        else if (state != IDLE && bus.imem_valid)
            state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc       <= '0;
            addr_q    <= '0;
            req_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            req_q <= issue;
            if (issue) begin
                addr_q <= fpc;
                fpc    <= fpc + PC_W'(4);
            end
            if (redirect) begin
                fpc       <= redirect_pc;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                occupancy <= occupancy + OW'(push) - OW'(pop);
            end
        end
    end
    // addr_q still holds the issued address while the response is awaited.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= addr_q;
            ins_mem[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors plus hand sequences for redirect, halt, reset and PC wrap
module tb_fetch_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic redirect = 1'b0;
    logic [8:0] redirect_pc = '0;
    logic halt = 1'b0;
    logic [2:0] occupancy;
    int total = 0;
    int bad = 0;
    int lat = 1;
    int cnt = 0;
    logic [8:0] addr_l = '0;

    fetch_queue_if #(.PC_W(9), .INS_W(32)) bus();

    fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .bus(bus), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'b0, a};
    endfunction

    // Instruction memory model: response arrives lat cycles after the request cycle.
    always @(posedge clk) begin
        bus.imem_valid <= 1'b0;
        if (bus.imem_req) begin
            addr_l <= bus.imem_addr;
            if (lat == 1) begin
                bus.imem_valid <= 1'b1;
                bus.imem_rdata <= mk(bus.imem_addr);
            end else
                cnt <= lat - 1;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                bus.imem_valid <= 1'b1;
                bus.imem_rdata <= mk(addr_l);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic er, input logic [8:0] ea,
                       input logic ev, input logic [8:0] ep, input logic [2:0] eo);
        logic [8:0] xp;
        logic [31:0] xi;
        logic ok;
        xp = ev ? ep : 9'h0;
        xi = ev ? mk(ep) : 32'h0;
        ok = bus.imem_req === er && bus.id_valid === ev && bus.id_pc === xp &&
             bus.id_instr === xi && occupancy === eo;
        if ((er || reset) && bus.imem_addr !== ea) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got req=%0d addr=%h v=%0d pc=%h ins=%h occ=%0d want req=%0d addr=%h v=%0d pc=%h ins=%h occ=%0d",
                     nm, bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, occupancy,
                     er, ea, ev, xp, xi, eo);
        end
    endtask

    typedef struct {
        logic rst;
        logic rdy;
        logic er;
        logic [8:0] ea;
        logic ev;
        logic [8:0] ep;
        logic [2:0] eo;
    } vec_t;

    initial begin
        vec_t tv[$];
        bus.id_ready = 1'b1;
        // reset, then steady fetch with 1-cycle imem latency
        tv.push_back('{1, 1, 0, 9'h0, 0, 9'h0, 0});
        tv.push_back('{1, 1, 0, 9'h0, 0, 9'h0, 0});
        tv.push_back('{0, 1, 1, 9'h0, 0, 9'h0, 0});
        tv.push_back('{0, 1, 0, 9'h0, 0, 9'h0, 0});
        tv.push_back('{0, 1, 0, 9'h0, 1, 9'h0, 1});
        tv.push_back('{0, 1, 1, 9'h4, 0, 9'h0, 0});
        tv.push_back('{0, 1, 0, 9'h0, 0, 9'h0, 0});
        tv.push_back('{0, 1, 0, 9'h0, 1, 9'h4, 1});
        tv.push_back('{0, 1, 1, 9'h8, 0, 9'h0, 0});
        tv.push_back('{0, 1, 0, 9'h0, 0, 9'h0, 0});
        tv.push_back('{0, 1, 0, 9'h0, 1, 9'h8, 1});
        // decode stalled for 12 cycles: fill to DEPTH, then no requests
        tv.push_back('{0, 0, 1, 9'hC, 1, 9'h8, 1});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 1});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 2});
        tv.push_back('{0, 0, 1, 9'h10, 1, 9'h8, 2});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 2});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 3});
        tv.push_back('{0, 0, 1, 9'h14, 1, 9'h8, 3});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 3});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 4});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 4});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 4});
        tv.push_back('{0, 0, 0, 9'h0, 1, 9'h8, 4});
        // release: drain in order, push+pop together keeps occupancy
        tv.push_back('{0, 1, 0, 9'h0, 1, 9'hC, 3});
        tv.push_back('{0, 1, 1, 9'h18, 1, 9'h10, 2});
        tv.push_back('{0, 1, 0, 9'h0, 1, 9'h14, 1});
        tv.push_back('{0, 1, 0, 9'h0, 1, 9'h18, 1});
        tv.push_back('{0, 1, 1, 9'h1C, 0, 9'h0, 0});
        tv.push_back('{0, 1, 0, 9'h0, 0, 9'h0, 0});
        tv.push_back('{0, 1, 0, 9'h0, 1, 9'h1C, 1});
        foreach (tv[i]) begin
            reset = tv[i].rst;
            bus.id_ready = tv[i].rdy;
            cyc();
            chk($sformatf("vec%0d", i), tv[i].er, tv[i].ea, tv[i].ev, tv[i].ep, tv[i].eo);
        end

        // redirect while waiting on a 3-cycle response
        lat = 3;
        reset = 1'b1;
        cyc();
        cyc();
        chk("t3_rst", 0, 9'h0, 0, 9'h0, 0);
        reset = 1'b0;
        cyc();
        chk("t3_req", 1, 9'h0, 0, 9'h0, 0);
        cyc();
        redirect = 1'b1;
        redirect_pc = 9'h40;
        cyc();
        redirect = 1'b0;
        chk("t3_flush", 0, 9'h0, 0, 9'h0, 0);
        cyc();
        cyc();
        chk("t3_drop", 0, 9'h0, 0, 9'h0, 0);
        cyc();
        chk("t3_req40", 1, 9'h40, 0, 9'h0, 0);
        for (int k = 0; k < 4; k++) cyc();
        chk("t3_head", 0, 9'h0, 1, 9'h40, 1);

        // redirect coincides with response and a pop
        lat = 1;
        bus.id_ready = 1'b0;
        cyc();
        chk("t4_req", 1, 9'h44, 1, 9'h40, 1);
        cyc();
        chk("t4_hold", 0, 9'h0, 1, 9'h40, 1);
        redirect = 1'b1;
        redirect_pc = 9'h80;
        bus.id_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        chk("t4_flush", 0, 9'h0, 0, 9'h0, 0);
        cyc();
        chk("t4_req80", 1, 9'h80, 0, 9'h0, 0);
        cyc();
        cyc();
        chk("t4_head", 0, 9'h0, 1, 9'h80, 1);

        // halt with a request outstanding
        cyc();
        chk("t5_req", 1, 9'h84, 0, 9'h0, 0);
        halt = 1'b1;
        cyc();
        chk("t5_wait", 0, 9'h0, 0, 9'h0, 0);
        cyc();
        chk("t5_push", 0, 9'h0, 1, 9'h84, 1);
        cyc();
        chk("t5_empty", 0, 9'h0, 0, 9'h0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t5_idle", 0, 9'h0, 0, 9'h0, 0);
        end

        // reset mid-WAIT after redirect to top of memory, then PC wrap
        halt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 9'h1FC;
        cyc();
        redirect = 1'b0;
        chk("t6_redir", 0, 9'h0, 0, 9'h0, 0);
        cyc();
        chk("t6_req1fc", 1, 9'h1FC, 0, 9'h0, 0);
        reset = 1'b1;
        cyc();
        chk("t6_rst", 0, 9'h0, 0, 9'h0, 0);
        cyc();
        chk("t6_rst2", 0, 9'h0, 0, 9'h0, 0);
        reset = 1'b0;
        cyc();
        chk("t6_req0", 1, 9'h0, 0, 9'h0, 0);
        cyc();
        cyc();
        chk("t6_push0", 0, 9'h0, 1, 9'h0, 1);
        redirect = 1'b1;
        redirect_pc = 9'h1FC;
        cyc();
        redirect = 1'b0;
        chk("t6_flush", 0, 9'h0, 0, 9'h0, 0);
        cyc();
        chk("t6_req1fc_b", 1, 9'h1FC, 0, 9'h0, 0);
        cyc();
        cyc();
        chk("t6_head1fc", 0, 9'h0, 1, 9'h1FC, 1);
        cyc();
        chk("t6_wrap", 1, 9'h0, 0, 9'h0, 0);
        cyc();
        cyc();
        chk("t6_head0", 0, 9'h0, 1, 9'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
